// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
//
// Elastic inter-stage pipeline register. Carries an opaque payload plus PC,
// delay-slot flag and exception code across valid/ready handshakes. A main
// register drives every out_* port and a skid register absorbs the one extra
// entry accepted while in_ready is still high, so the registered in_ready
// never costs throughput.
//
// Overrides, highest priority first: rst, req (bubble at EXC_PC), flush
// (bubble that keeps PC and slot), then normal handshake operation.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req                           exception entry: empty the stage, out_pc <= EXC_PC
//   flush                         bubble insert: empty the stage, hold out_pc/out_slot
//   in_valid / in_ready           upstream handshake (in_ready is a flop)
//   in_data/in_pc/in_slot/in_exc  incoming entry
//   out_valid / out_ready         downstream handshake
//   out_data/out_pc/out_slot/out_exc  main-entry fields
//   occupancy                     entries held: 0, 1 or 2
//
// state | meaning
// EMPTY | no entry held; outputs show a bubble
// ONE   | main register valid, skid register free
// FULL  | main and skid both valid; in_ready low

module pipe_stage_buf #(
    parameter int              DATA_W   = 128,
    parameter int              PC_W     = 32,
    parameter int              EXC_W    = 5,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_3000,
    parameter logic [PC_W-1:0] EXC_PC   = 32'h0000_4180
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              in_slot,
    input  logic [EXC_W-1:0]  in_exc,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    output logic              out_slot,
    output logic [EXC_W-1:0]  out_exc,

    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               in_ready_q;

    logic [DATA_W-1:0]  main_data_q;
    logic [PC_W-1:0]    main_pc_q;
    logic               main_slot_q;
    logic [EXC_W-1:0]   main_exc_q;

    logic [DATA_W-1:0]  skid_data_q;
    logic [PC_W-1:0]    skid_pc_q;
    logic               skid_slot_q;
    logic [EXC_W-1:0]   skid_exc_q;

    logic               push;
    logic               pop;

    // in_ready_q always equals (state_q != FULL), so push never depends on
    // anything combinational from the downstream side.
    assign push = in_valid & in_ready_q;
    assign pop  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:   if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (!push && pop) state_d = EMPTY;
            end
            FULL:    if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || req) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            main_data_q <= '0;
            main_exc_q  <= '0;
            main_slot_q <= 1'b0;
            main_pc_q   <= rst ? RESET_PC : EXC_PC;
            skid_data_q <= '0;
            skid_pc_q   <= '0;
            skid_slot_q <= 1'b0;
            skid_exc_q  <= '0;
        end else if (flush) begin
            // PC and slot stay put so the bubble still reports where the
            // stage was; the incoming entry and any pop are dropped.
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            main_data_q <= '0;
            main_exc_q  <= '0;
            skid_data_q <= '0;
            skid_exc_q  <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        main_data_q <= in_data;
                        main_pc_q   <= in_pc;
                        main_slot_q <= in_slot;
                        main_exc_q  <= in_exc;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_data_q <= in_data;
                        main_pc_q   <= in_pc;
                        main_slot_q <= in_slot;
                        main_exc_q  <= in_exc;
                    end else if (push) begin
                        skid_data_q <= in_data;
                        skid_pc_q   <= in_pc;
                        skid_slot_q <= in_slot;
                        skid_exc_q  <= in_exc;
                    end else if (pop) begin
                        // Draining to a bubble: clear payload, keep PC/slot.
                        main_data_q <= '0;
                        main_exc_q  <= '0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_data_q <= skid_data_q;
                        main_pc_q   <= skid_pc_q;
                        main_slot_q <= skid_slot_q;
                        main_exc_q  <= skid_exc_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_data_q;
    assign out_pc    = main_pc_q;
    assign out_slot  = main_slot_q;
    assign out_exc   = main_exc_q;
    assign occupancy = (state_q == FULL) ? 2'd2 :
                       (state_q == ONE)  ? 2'd1 : 2'd0;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: a table of per-cycle vectors with
// hand-computed expected outputs, plus short hand-written sequences.

module tb_pipe_stage_buf;

    logic         clk = 1'b0;
    logic         rst, req, flush;
    logic         in_valid, in_ready, in_slot, out_valid, out_ready, out_slot;
    logic [127:0] in_data, out_data;
    logic [31:0]  in_pc, out_pc;
    logic [4:0]   in_exc, out_exc;
    logic [1:0]   occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_buf dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_pc     (in_pc),
        .in_slot   (in_slot),
        .in_exc    (in_exc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_pc    (out_pc),
        .out_slot  (out_slot),
        .out_exc   (out_exc),
        .occupancy (occupancy)
    );

    typedef struct {
        logic         rst, req, flush, iv;
        logic [31:0]  ipc;
        logic [127:0] idata;
        logic         islot;
        logic [4:0]   iexc;
        logic         ordy;
        logic         ev;
        logic [31:0]  epc;
        logic [127:0] edata;
        logic         eslot;
        logic [4:0]   eexc;
        logic [1:0]   eocc;
        logic         erdy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r, input logic q, input logic f, input logic iv,
        input logic [31:0] ipc, input logic [31:0] id, input logic is,
        input logic [4:0] ie, input logic ordy,
        input logic ev, input logic [31:0] epc, input logic [31:0] ed,
        input logic es, input logic [4:0] ee, input logic [1:0] eocc,
        input logic erdy);
        vec_t v;
        v.rst = r;  v.req = q;  v.flush = f;  v.iv = iv;
        v.ipc = ipc; v.idata = {96'h5a5a_0000_0000_0000_0000_0001, id};
        v.islot = is; v.iexc = ie; v.ordy = ordy;
        v.ev = ev; v.epc = epc;
        v.edata = (ed == 32'h0) ? 128'h0 : {96'h5a5a_0000_0000_0000_0000_0001, ed};
        v.eslot = es; v.eexc = ee; v.eocc = eocc; v.erdy = erdy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; req = v.req; flush = v.flush; in_valid = v.iv;
        in_pc = v.ipc; in_data = v.idata; in_slot = v.islot; in_exc = v.iexc;
        out_ready = v.ordy;
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        string s;
        s = $sformatf("v%0d", idx);
        chk({s, ".out_valid"}, 128'(out_valid), 128'(v.ev));
        chk({s, ".out_pc"},    128'(out_pc),    128'(v.epc));
        chk({s, ".out_data"},  out_data,        v.edata);
        chk({s, ".out_slot"},  128'(out_slot),  128'(v.eslot));
        chk({s, ".out_exc"},   128'(out_exc),   128'(v.eexc));
        chk({s, ".occupancy"}, 128'(occupancy), 128'(v.eocc));
        chk({s, ".in_ready"},  128'(in_ready),  128'(v.erdy));
    endtask

    initial begin
        //            rst req fl iv  in_pc        dat   sl ex     ordy  ev  exp_pc       dat   sl ex     occ rdy
        // reset
        vecs.push_back(mk(1,0,0,0, 32'h0,        32'h0,  0,5'h0, 0,    0, 32'h3000, 32'h0,  0,5'h0, 0, 1));
        vecs.push_back(mk(1,0,0,0, 32'h0,        32'h0,  0,5'h0, 0,    0, 32'h3000, 32'h0,  0,5'h0, 0, 1));
        // streaming with out_ready high
        vecs.push_back(mk(0,0,0,1, 32'h3000, 32'h11, 0,5'h0, 1,    1, 32'h3000, 32'h11, 0,5'h0, 1, 1));
        vecs.push_back(mk(0,0,0,1, 32'h3004, 32'h22, 1,5'h3, 1,    1, 32'h3004, 32'h22, 1,5'h3, 1, 1));
        vecs.push_back(mk(0,0,0,1, 32'h3008, 32'h33, 0,5'h0, 1,    1, 32'h3008, 32'h33, 0,5'h0, 1, 1));
        vecs.push_back(mk(0,0,0,0, 32'h0,    32'h0,  0,5'h0, 1,    0, 32'h3008, 32'h0,  0,5'h0, 0, 1));
        // backpressure: A then B, blocked push in FULL, then drain
        vecs.push_back(mk(0,0,0,1, 32'h300c, 32'h44, 1,5'h1, 0,    1, 32'h300c, 32'h44, 1,5'h1, 1, 1));
        vecs.push_back(mk(0,0,0,1, 32'h3010, 32'h55, 0,5'h2, 0,    1, 32'h300c, 32'h44, 1,5'h1, 2, 0));
        vecs.push_back(mk(0,0,0,1, 32'h3020, 32'h99, 1,5'h9, 0,    1, 32'h300c, 32'h44, 1,5'h1, 2, 0));
        vecs.push_back(mk(0,0,0,0, 32'h0,    32'h0,  0,5'h0, 1,    1, 32'h3010, 32'h55, 0,5'h2, 1, 1));
        vecs.push_back(mk(0,0,0,0, 32'h0,    32'h0,  0,5'h0, 1,    0, 32'h3010, 32'h0,  0,5'h0, 0, 1));
        // flush with concurrent push
        vecs.push_back(mk(0,0,0,1, 32'h3010, 32'h66, 1,5'h4, 0,    1, 32'h3010, 32'h66, 1,5'h4, 1, 1));
        vecs.push_back(mk(0,0,1,1, 32'h3014, 32'h77, 0,5'h7, 0,    0, 32'h3010, 32'h0,  1,5'h0, 0, 1));
        vecs.push_back(mk(0,0,0,0, 32'h0,    32'h0,  0,5'h0, 1,    0, 32'h3010, 32'h0,  1,5'h0, 0, 1));
        // exception entry from FULL, together with flush and a pop
        vecs.push_back(mk(0,0,0,1, 32'h3018, 32'h88, 1,5'h6, 0,    1, 32'h3018, 32'h88, 1,5'h6, 1, 1));
        vecs.push_back(mk(0,0,0,1, 32'h301c, 32'h9a, 0,5'ha, 0,    1, 32'h3018, 32'h88, 1,5'h6, 2, 0));
        vecs.push_back(mk(0,1,1,0, 32'h0,    32'h0,  0,5'h0, 1,    0, 32'h4180, 32'h0,  0,5'h0, 0, 1));
        // reset from FULL, then single-cycle latency
        vecs.push_back(mk(0,0,0,1, 32'h3020, 32'haa, 1,5'ha, 0,    1, 32'h3020, 32'haa, 1,5'ha, 1, 1));
        vecs.push_back(mk(0,0,0,1, 32'h3024, 32'hbb, 0,5'h1, 0,    1, 32'h3020, 32'haa, 1,5'ha, 2, 0));
        vecs.push_back(mk(1,0,0,1, 32'h3030, 32'hdd, 1,5'h3, 1,    0, 32'h3000, 32'h0,  0,5'h0, 0, 1));
        vecs.push_back(mk(0,0,0,1, 32'h3028, 32'hcc, 1,5'h2, 1,    1, 32'h3028, 32'hcc, 1,5'h2, 1, 1));
        vecs.push_back(mk(0,0,0,0, 32'h0,    32'h0,  0,5'h0, 1,    0, 32'h3028, 32'h0,  1,5'h0, 0, 1));
        // req with concurrent push from ONE; rst beats req
        vecs.push_back(mk(0,0,0,1, 32'h302c, 32'hee, 0,5'h5, 0,    1, 32'h302c, 32'hee, 0,5'h5, 1, 1));
        vecs.push_back(mk(0,1,0,1, 32'h3030, 32'hff, 1,5'h6, 0,    0, 32'h4180, 32'h0,  0,5'h0, 0, 1));
        vecs.push_back(mk(0,0,0,0, 32'h0,    32'h0,  0,5'h0, 0,    0, 32'h4180, 32'h0,  0,5'h0, 0, 1));
        vecs.push_back(mk(1,1,1,0, 32'h0,    32'h0,  0,5'h0, 0,    0, 32'h3000, 32'h0,  0,5'h0, 0, 1));

        rst = 1'b1; req = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_data = '0; in_slot = 1'b0; in_exc = '0;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge clk); #1;
            check_vec(i, vecs[i]);
        end

        // Hand sequence: fill to FULL, then show in_ready does not react
        // combinationally to out_ready, and rises only after the pop edge.
        rst = 0; req = 0; flush = 0; out_ready = 0;
        in_valid = 1; in_pc = 32'h3100; in_data = 128'h1; in_slot = 0; in_exc = 5'h0;
        @(posedge clk); #1;
        in_pc = 32'h3104; in_data = 128'h2;
        @(posedge clk); #1;
        in_valid = 0;
        out_ready = 1;
        #2;
        chk("hs.in_ready_no_comb", 128'(in_ready), 128'(1'b0));
        @(posedge clk); #1;
        chk("hs.in_ready_after_pop", 128'(in_ready), 128'(1'b1));
        chk("hs.fifo_order_pc", 128'(out_pc), 128'(32'h3104));
        @(posedge clk); #1;
        chk("hs.drained", 128'(occupancy), 128'(2'd0));

        // Hand sequence: bounded wait for a pushed entry to appear.
        in_valid = 1; in_pc = 32'h3200; in_data = 128'h77; out_ready = 0;
        @(posedge clk); #1;
        in_valid = 0;
        begin
            int waited = 0;
            while (!out_valid && waited < 8) begin
                @(posedge clk); #1;
                waited++;
            end
            chk("hs.latency_cycles", 128'(waited), 128'(0));
            chk("hs.latency_pc", 128'(out_pc), 128'(32'h3200));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised, elastic successor to the fixed inter-stage pipeline registers. Carries one opaque payload word plus PC, delay-slot flag and exception code from one stage to the next over valid/ready handshakes, with a 2-entry skid buffer so the registered `in_ready` never blocks throughput. Supports the same three control overrides as the existing stage registers:

- synchronous reset;
- exception entry (`req`), which forces a bubble at the handler PC;
- `flush`, which forces a bubble and preserves PC and slot.

## Interface

- DATA_W, 128, payload width (packed control and data fields)
- PC_W, 32, PC width
- EXC_W, 5, exception-code width
- RESET_PC, 32'h0000_3000, `out_pc` after reset
- EXC_PC, 32'h0000_4180, `out_pc` after `req`

- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  1  exception entry; clears the stage and loads EXC_PC
- flush  in  1  bubble insert; clears the stage and holds PC and slot
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; registered
- in_data  in  DATA_W  payload
- in_pc  in  PC_W  instruction PC
- in_slot  in  1  delay-slot flag
- in_exc  in  EXC_W  exception code
- out_valid  out  1  main entry valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  main-entry payload
- out_pc  out  PC_W  main-entry PC
- out_slot  out  1  main-entry slot flag
- out_exc  out  EXC_W  main-entry exception code
- occupancy  out  2  entries held: 0, 1 or 2

## Operation

- Storage is a main register (drives all `out_*`) and a skid register.
- State is EMPTY, ONE or FULL. `occupancy` reads 0, 1 or 2 respectively.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (state != FULL), registered from the next-state value.
- Transitions:
  - EMPTY, push: main <= in, go to ONE.
  - ONE, push & pop: main <= in, stay in ONE.
  - ONE, push only: skid <= in, go to FULL.
  - ONE, pop only: go to EMPTY.
  - FULL, pop: main <= skid, go to ONE. No push is possible in FULL.
- Going to EMPTY by pop: out_data and out_exc become 0. out_pc and out_slot hold their last values.
- Priority order: rst > req > flush > normal.
- rst:
  - All entries invalid, state EMPTY, in_ready=1.
  - out_data=0, out_exc=0, out_slot=0, out_pc=RESET_PC.
- req:
  - Same as rst, except out_pc=EXC_PC.
  - Any push in the same cycle is dropped.
- flush:
  - State EMPTY; both entries invalidated.
  - out_data=0, out_exc=0.
  - out_pc and out_slot keep their current values; they are not loaded from `in_*`.
  - Any push in the same cycle is dropped.
- A drop is still a completed handshake from the producer's side. The producer must not retry.
- Payload is never inspected or modified.
- A bubble is always out_valid=0 with out_data=0.

## Timing

- Latency: 1 cycle from push to out_valid when EMPTY or ONE-with-pop.
- Throughput: 1 entry per cycle when out_ready is held high.
- in_ready falls the cycle after the skid fills. It rises the cycle after a pop from FULL.
- in_ready has no combinational path from out_ready.
- Ordering is strict FIFO: the skid entry always leaves after the main entry.
- rst, req and flush take effect at the next clock edge. Outputs reflect the override in the following cycle. Any pop asserted in the override cycle is discarded along with the entries.
- Reset applied mid-operation (state FULL) discards both entries with no partial output.

## Test plan

- Reset: hold rst 2 cycles → out_valid=0, occupancy=0, in_ready=1, out_pc=32'h3000, out_data=0, out_exc=0, out_slot=0.
- Streaming: push pc 0x3000, 0x3004, 0x3008 on back-to-back cycles with out_ready=1 → out_pc presents each one cycle later; occupancy stays 1; in_ready stays 1.
- Backpressure: out_ready=0, push A then B → occupancy=2, in_ready=0 the next cycle. Raise out_ready → A, then B, each for one cycle, then occupancy=0 with out_pc=B.pc.
- Flush: with main holding pc 0x3010 and slot=1, assert flush together with in_valid for pc 0x3014 → next cycle out_valid=0, out_pc=0x3010, out_slot=1, out_exc=0, occupancy=0; the 0x3014 entry never appears at the output.
- Exception entry: state FULL, assert req and flush together → next cycle out_pc=32'h4180, out_slot=0, out_valid=0, in_ready=1.
- Reset mid-operation: state FULL with out_exc=5'h0a, assert rst for 1 cycle → all reset values; a subsequent push emerges after exactly 1 cycle.
